// File: rtl/cos_horner_if.sv
// Request/response bundle for the sequential cos(x) engine.
interface cos_horner_if;
  logic        start;
  logic [31:0] in_1;
  logic        abort;
  logic        ready;
  logic        done;
  logic [31:0] out_1;
  logic        err;

  modport master (output start, in_1, abort, input ready, done, out_1, err);
  modport slave  (input start, in_1, abort, output ready, done, out_1, err);
endinterface

// File: rtl/cos_horner_seq.sv
// Sequential IEEE-754 single cos(x): Horner series evaluated on one shared
// multiplier and one shared add/sub unit, subnormals flushed to zero.
module cos_horner_seq #(
  parameter int unsigned N_TERMS   = 5,
  parameter int unsigned STEP_WAIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  cos_horner_if.slave  bus
);
  localparam int unsigned KW = 3;
  localparam int unsigned WW = 4;
  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_MC, S_MT, S_SUB} state_t;

  // Multiply with RNE rounding; returns {invalid, overflow, underflow, result}.
  function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn, inv, ovf, unf, g, st;
    logic [47:0] prod;
    logic [22:0] m;
    logic [31:0] r;
    int          e;
    sgn  = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (prod[47]) begin
      e = int'(a[30:23]) + int'(b[30:23]) - 126;
      m = prod[46:24]; g = prod[23]; st = |prod[22:0];
    end else begin
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      m = prod[45:23]; g = prod[22]; st = |prod[21:0];
    end
    inv = 1'b0; ovf = 1'b0; unf = 1'b0; r = '0;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0) ||
        (a[30:23] == 8'hFF && b[30:23] == 8'h00) || (b[30:23] == 8'hFF && a[30:23] == 8'h00)) begin
      inv = 1'b1; r = QNAN;
    end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      ovf = 1'b1; r = {sgn, 8'hFF, 23'h0};
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      r = {sgn, 31'h0};
    end else if (e >= 255) begin
      ovf = 1'b1; r = {sgn, 8'hFF, 23'h0};
    end else if (e <= 0) begin
      unf = 1'b1; r = {sgn, 31'h0};
    end else begin
      // A rounding carry out of the mantissa bumps the exponent, possibly to inf.
      r   = {sgn, 8'(e), m} + 32'(g & (st | m[0]));
      ovf = (r[30:23] == 8'hFF);
    end
    return {inv, ovf, unf, r};
  endfunction

  // Add/sub (op=1: a-b) with RNE rounding; returns {flag, result}.
  function automatic logic [32:0] fp_addsub(input logic [31:0] a, input logic [31:0] b_in,
                                            input logic op);
    logic [31:0] b, big, sml, r;
    logic [63:0] sh;
    logic [27:0] sum;
    logic [26:0] n, big27, s27;
    logic        flg, g, st, found;
    int          d, e, lz;
    b   = {b_in[31] ^ op, b_in[30:0]};
    flg = 1'b0; r = '0; n = '0; lz = 0; found = 1'b0;
    big = (b[30:0] > a[30:0]) ? b : a;
    sml = (b[30:0] > a[30:0]) ? a : b;
    d   = int'(big[30:23]) - int'(sml[30:23]);
    if (d > 63) d = 63;
    sh    = {1'b1, sml[22:0], 40'h0} >> d;
    s27   = {sh[63:38], sh[37] | (|sh[36:0])};
    big27 = {1'b1, big[22:0], 3'b000};
    sum   = (big[31] == sml[31]) ? {1'b0, big27} + {1'b0, s27} : {1'b0, big27} - {1'b0, s27};
    e     = int'(big[30:23]);
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz = 26 - i; found = 1'b1;
        end
      end
      n = sum[26:0] << lz;
      e = e - lz;
    end
    g  = n[2];
    st = |n[1:0];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0) ||
        (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])) begin
      flg = 1'b1; r = QNAN;
    end else if (a[30:23] == 8'hFF) begin
      flg = 1'b1; r = a;
    end else if (b[30:23] == 8'hFF) begin
      flg = 1'b1; r = b;
    end else if (b[30:23] == 8'h00) begin
      r = (a[30:23] == 8'h00) ? 32'h0 : a;
    end else if (a[30:23] == 8'h00) begin
      r = b;
    end else if (sum == '0) begin
      r = 32'h0;
    end else if (e >= 255) begin
      flg = 1'b1; r = {big[31], 8'hFF, 23'h0};
    end else if (e <= 0) begin
      flg = 1'b1; r = {big[31], 31'h0};
    end else begin
      r   = {big[31], 8'(e), n[25:3]} + 32'(g & (st | n[3]));
      flg = (r[30:23] == 8'hFF);
    end
    return {flg, r};
  endfunction

  state_t          r_state;
  logic            r_ready, r_done, r_err, r_acc;
  logic [31:0]     r_out, r_x, r_z, r_p, r_q, r_t;
  logic [KW-1:0]   r_k;
  logic [WW-1:0]   r_wait;

  logic [31:0]     w_coef, w_ma, w_mb, w_mul, w_add;
  logic [2:0]      w_mul_flg;
  logic            w_add_flg, w_last;

  // Horner coefficients 1/((2k+1)(2k+2)).
  always_comb begin
    case (r_k)
      3'd0:    w_coef = 32'h3F000000;
      3'd1:    w_coef = 32'h3DAAAAAB;
      3'd2:    w_coef = 32'h3D088889;
      3'd3:    w_coef = 32'h3C924925;
      default: w_coef = 32'h3C360B61;
    endcase
  end

  // Shared multiplier operand mux, fed from registers only.
  always_comb begin
    w_ma = r_x;
    w_mb = r_x;
    case (r_state)
      S_MC:    begin w_ma = r_z; w_mb = w_coef; end
      S_MT:    begin w_ma = r_p; w_mb = r_t;    end
      default: ;
    endcase
  end

  assign {w_mul_flg, w_mul} = fp_mul(w_ma, w_mb);
  assign {w_add_flg, w_add} = fp_addsub(ONE, r_q, 1'b1);
  assign w_last             = (r_wait == WW'(STEP_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= 1'b0;
      r_out   <= '0;
      r_x     <= '0;
      r_z     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_t     <= '0;
      r_k     <= '0;
      r_wait  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_x     <= bus.in_1;
          r_t     <= ONE;
          r_k     <= KW'(N_TERMS - 1);
          r_acc   <= 1'b0;
          r_wait  <= '0;
          r_ready <= 1'b0;
          r_state <= S_SQ;
        end
      end else if (bus.abort) begin
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        r_wait  <= '0;
      end else if (!w_last) begin
        r_wait <= r_wait + WW'(1);
      end else begin
        r_wait <= '0;
        case (r_state)
          S_SQ: begin
            r_z     <= w_mul;
            r_acc   <= r_acc | (|w_mul_flg);
            r_state <= S_MC;
          end
          S_MC: begin
            r_p     <= w_mul;
            r_acc   <= r_acc | (|w_mul_flg);
            r_state <= S_MT;
          end
          S_MT: begin
            r_q     <= w_mul;
            r_acc   <= r_acc | (|w_mul_flg);
            r_state <= S_SUB;
          end
          S_SUB: begin
            r_t   <= w_add;
            r_acc <= r_acc | w_add_flg;
            if (r_k == '0) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_out   <= w_add;
              r_err   <= r_acc | w_add_flg;
            end else begin
              r_k     <= r_k - KW'(1);
              r_state <= S_MC;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.out_1 = r_out;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_cos_horner_seq.sv
// Scoreboard bench for cos_horner_seq: truncated Taylor series in reals as the
// reference, plus two extra instances for the N_TERMS / STEP_WAIT corners.
module tb_cos_horner_seq;
  localparam int LAT = 16;

  typedef struct {
    logic [31:0] val;
    int          tol;
    logic        is_nan;
    logic        err;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t m_e;
  exp_t last_e;

  cos_horner_if b0();
  cos_horner_if b1();
  cos_horner_if b2();

  cos_horner_seq #(.N_TERMS(5), .STEP_WAIT(0)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(b0));
  cos_horner_seq #(.N_TERMS(5), .STEP_WAIT(2)) u_dut_sw (.clk(clk), .rst_n(rst_n), .bus(b1));
  cos_horner_seq #(.N_TERMS(1), .STEP_WAIT(0)) u_dut_n1 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [31:0] f;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    f = {d[63], 8'(e), d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) f = f + 32'd1;
    return f;
  endfunction

  // cos(x) series through x^(2n)/(2n)!, which is what n Horner stages compute.
  function automatic exp_t model(input logic [31:0] x, input int nterms, input int done_cyc);
    exp_t r;
    real  xr, z, sum, term;
    r.done_cyc = done_cyc;
    if (x[30:23] == 8'hFF) begin
      r.val = 32'h7FC00000; r.tol = 0; r.is_nan = 1'b1; r.err = 1'b1;
      return r;
    end
    xr = f2r(x); z = xr * xr; sum = 0.0; term = 1.0;
    for (int i = 0; i <= nterms; i++) begin
      sum  = sum + term;
      term = -term * z / real'((2 * i + 1) * (2 * i + 2));
    end
    r.val = r2f(sum); r.is_nan = 1'b0; r.err = 1'b0;
    r.tol = (x[30:0] == 31'h0) ? 0 : 4;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req,
                       input int tol);
    logic [31:0] d;
    d = (act > req) ? act - req : req - act;
    checks++;
    if (d > 32'(tol)) begin
      errors++;
      $display("FAIL %s: got %08h want %08h (tol %0d) at cycle %0d", nm, act, req, tol, cyc);
    end
  endtask

  // Monitor: every done is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && b0.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
      end else begin
        m_e = sb.pop_front();
        check("latency", 32'(cyc), 32'(m_e.done_cyc), 0);
        if (m_e.is_nan)
          check("nan_out", 32'(b0.out_1[30:23] == 8'hFF && b0.out_1[22:0] != '0), 32'd1, 0);
        else
          check("cos_out", b0.out_1, m_e.val, m_e.tol);
        check("err", 32'(b0.err), 32'(m_e.err), 0);
        last_e = m_e;
      end
    end
  end

  task automatic issue(input logic [31:0] x);
    for (int i = 0; i < 200 && !b0.ready; i++) @(negedge clk);
    b0.start = 1'b1;
    b0.in_1  = x;
    if (b0.ready) sb.push_back(model(x, 5, cyc + 1 + LAT));
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rnd_x();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(126, 100)), 23'($urandom)};
  endfunction

  initial begin
    int acc;
    b0.start = 1'b0; b0.in_1 = '0; b0.abort = 1'b0;
    b1.start = 1'b0; b1.in_1 = '0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.in_1 = '0; b2.abort = 1'b0;
    last_e = model(32'h0, 5, 0);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(b0.ready), 32'd1, 0);
    check("rst_done", 32'(b0.done), 32'd0, 0);
    check("rst_out", b0.out_1, 32'h0, 0);
    check("rst_err", 32'(b0.err), 32'd0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed points, then NaN propagation and a clean op afterwards.
    issue(32'h3F860A92);
    issue(32'h3F060A92);
    issue(32'hBF860A92);
    issue(32'h00000000);
    issue(32'h7FC00000);
    issue(32'h3F000000);
    drain("directed");

    for (int n = 0; n < 20; n++) issue(rnd_x());
    drain("random");

    // start held high: each done cycle must accept the next request.
    b0.start = 1'b1;
    for (int n = 0; n < 4 * LAT; n++) begin
      b0.in_1 = rnd_x();
      if (b0.ready) sb.push_back(model(b0.in_1, 5, cyc + 1 + LAT));
      @(negedge clk);
    end
    b0.start = 1'b0;
    drain("held");

    // Pulses while busy must be dropped, not queued.
    issue(rnd_x());
    repeat (3) @(negedge clk);
    check("busy_ready", 32'(b0.ready), 32'd0, 0);
    b0.start = 1'b1; b0.in_1 = 32'h3F800000;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (4) @(negedge clk);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    drain("ignored");
    repeat (LAT + 4) @(negedge clk);

    // Abort mid-op: back to idle, no done, previous result kept.
    b0.start = 1'b1; b0.in_1 = rnd_x();
    acc = cyc + 1;
    @(negedge clk);
    b0.start = 1'b0;
    while (cyc < acc + 6) @(negedge clk);
    check("abort_busy", 32'(b0.ready), 32'd0, 0);
    b0.abort = 1'b1;
    @(negedge clk);
    b0.abort = 1'b0;
    check("abort_ready", 32'(b0.ready), 32'd1, 0);
    check("abort_out", b0.out_1, last_e.val, last_e.tol);
    check("abort_err", 32'(b0.err), 32'(last_e.err), 0);
    repeat (LAT + 4) @(negedge clk);

    // start and abort together in idle: start wins.
    b0.start = 1'b1; b0.abort = 1'b1; b0.in_1 = 32'h3F060A92;
    if (b0.ready) sb.push_back(model(b0.in_1, 5, cyc + 1 + LAT));
    @(negedge clk);
    b0.start = 1'b0; b0.abort = 1'b0;
    drain("start_abort");

    // STEP_WAIT=2 instance.
    b1.start = 1'b1; b1.in_1 = 32'h3F860A92;
    acc = cyc + 1;
    @(negedge clk);
    b1.start = 1'b0;
    for (int i = 0; i < 100 && !b1.done; i++) @(negedge clk);
    check("sw2_latency", 32'(cyc - acc), 32'd48, 0);
    m_e = model(32'h3F860A92, 5, 0);
    check("sw2_out", b1.out_1, m_e.val, m_e.tol);
    check("sw2_err", 32'(b1.err), 32'd0, 0);

    // N_TERMS=1 instance: 1 - 1*0.5 is exact.
    b2.start = 1'b1; b2.in_1 = 32'h3F800000;
    acc = cyc + 1;
    @(negedge clk);
    b2.start = 1'b0;
    for (int i = 0; i < 100 && !b2.done; i++) @(negedge clk);
    check("n1_latency", 32'(cyc - acc), 32'd4, 0);
    m_e = model(32'h3F800000, 1, 0);
    check("n1_out", b2.out_1, m_e.val, 0);

    // Async reset mid-op clears outputs without waiting for a clock edge.
    issue(32'h3F860A92);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(b0.ready), 32'd1, 0);
    check("arst_done", 32'(b0.done), 32'd0, 0);
    check("arst_out", b0.out_1, 32'h0, 0);
    check("arst_err", 32'(b0.err), 32'd0, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    issue(32'h3F060A92);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish by 1000000");
    $fatal(1, "watchdog");
  end
endmodule
